// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART TX buffer arbiter:
//   arb_state_t  - arbiter state (IDLE / XFER)
//   gid_width()  - width of a requester index, never less than one bit
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    function automatic int gid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. It searches the request vector starting
// at ptr+1 and wrapping around, so the requester at ptr ranks lowest.
// Ports:
//   req   [NUM_REQ-1:0] request vector
//   ptr   [GID_W-1:0]   index of the most recently served requester
//   found               at least one request is set
//   index [GID_W-1:0]   winning requester (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GID_W   = gid_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic               found,
    output logic [GID_W-1:0]   index
);

    localparam logic [GID_W:0] NUM_REQ_W = (GID_W+1)'(NUM_REQ);

    // rot[k] is the request that sits k+1 places after ptr; cand[k] is its index.
    logic [NUM_REQ-1:0] rot;
    logic [GID_W-1:0]   cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [GID_W:0] sum;
            // ptr < NUM_REQ and gi+1 <= NUM_REQ, so one conditional subtract wraps it.
            assign sum      = {1'b0, ptr} + (GID_W+1)'(gi + 1);
            assign cand[gi] = (sum >= NUM_REQ_W) ? GID_W'(sum - NUM_REQ_W) : sum[GID_W-1:0];
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest rotated position wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the single UART TX word buffer among NUM_REQ requesters. One requester
// is granted at a time, round-robin, and its words are streamed straight into
// the buffer write port. A grant ends on a word flagged last, on reaching
// MAX_BURST words, or when the granted requester stays idle for STALL_LIMIT
// cycles. Every release is followed by one IDLE cycle before the next grant.
//
// Optional feature: define UART_ARB_PRIO_EN to make requester 0 win every
// arbitration it takes part in (without moving the round-robin pointer).
//
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   req_valid/last [N]     per-requester handshake
//   req_data [N*W]         packed words, requester i at [i*W +: W]
//   req_ready [N]          accept, one-hot or zero
//   buf_full               TX buffer full flag
//   buf_wr, buf_data       TX buffer write strobe and data
//   grant_id               current or last granted requester
//   busy                   high while a grant is active
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int WORD_SIZE   = 32,
    parameter  int MAX_BURST   = 16,
    parameter  int STALL_LIMIT = 255,
    localparam int GID_W       = gid_width(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         buf_full,
    output logic                         buf_wr,
    output logic [WORD_SIZE-1:0]         buf_data,
    output logic [GID_W-1:0]             grant_id,
    output logic                         busy
);

    arb_state_t       state_reg, state_next;
    logic [GID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GID_W-1:0] grant_id_reg, grant_id_next;
    logic [7:0]       burst_cnt_reg, burst_cnt_next;
    logic [15:0]      stall_cnt_reg, stall_cnt_next;

    logic [WORD_SIZE-1:0] word_arr [NUM_REQ];
    logic                 pick_found;
    logic [GID_W-1:0]     pick_idx;
    logic                 in_xfer, g_valid, g_last, xfer;
    logic                 burst_done, stall_done, prio_hit;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .index (pick_idx)
    );

    // Reset gates the strobes so a word offered in the reset cycle is not taken.
    assign in_xfer = (state_reg == XFER) && !reset;
    assign g_valid = req_valid[grant_id_reg];
    assign g_last  = req_last[grant_id_reg];
    assign xfer    = in_xfer && g_valid && !buf_full;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign word_arr[gi]  = req_data[gi*WORD_SIZE +: WORD_SIZE];
            assign req_ready[gi] = in_xfer && !buf_full && (grant_id_reg == GID_W'(gi));
        end
    endgenerate

    assign buf_wr   = xfer;
    assign buf_data = word_arr[grant_id_reg];
    assign grant_id = grant_id_reg;
    assign busy     = (state_reg == XFER);

    assign burst_done = ({1'b0, burst_cnt_reg} + 9'd1) == 9'(MAX_BURST);
    // stall_cnt saturates at STALL_LIMIT-1, so a requester that goes idle after
    // a long buf_full stall is released on the next edge instead of never.
    assign stall_done = ({1'b0, stall_cnt_reg} + 17'd1) == 17'(STALL_LIMIT);

`ifdef UART_ARB_PRIO_EN
    assign prio_hit = req_valid[0];
`else
    assign prio_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        burst_cnt_next = burst_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (prio_hit) begin
                    // Priority grant leaves the round-robin order untouched.
                    grant_id_next  = '0;
                    burst_cnt_next = '0;
                    stall_cnt_next = '0;
                    state_next     = XFER;
                end else if (pick_found) begin
                    grant_id_next  = pick_idx;
                    rr_ptr_next    = pick_idx;
                    burst_cnt_next = '0;
                    stall_cnt_next = '0;
                    state_next     = XFER;
                end
            end
            XFER: begin
                if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 8'd1;
                    stall_cnt_next = '0;
                    if (g_last || burst_done) begin
                        state_next = IDLE;
                    end
                end else begin
                    if (!stall_done) begin
                        stall_cnt_next = stall_cnt_reg + 16'd1;
                    end
                    // Back-pressure alone never releases a valid requester.
                    if (!g_valid && stall_done) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= GID_W'(NUM_REQ - 1);
            grant_id_reg  <= '0;
            burst_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            burst_cnt_reg <= burst_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed scenarios with literal expectations followed by a randomized phase.
// A behavioural model (owner / last served / word and idle counts) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int MAXB  = 16;
    localparam int STALL = 8;
`ifdef UART_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [N*W-1:0] req_data;
    logic           buf_full, buf_wr, busy;
    logic [W-1:0]   buf_data;
    logic [1:0]     grant_id;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ(N), .WORD_SIZE(W), .MAX_BURST(MAXB), .STALL_LIMIT(STALL)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .buf_full(buf_full), .buf_wr(buf_wr),
        .buf_data(buf_data), .grant_id(grant_id), .busy(busy)
    );

    // ---------------- stimulus-side state ----------------
    logic [W:0]   q [N][$];   // {last, data} per requester
    bit           rand_mode = 1'b0;
    int           pause [N];
    int           words_pushed = 0;
    bit           chk_en = 1'b0, done = 1'b0, drain_to = 1'b0;
    bit           lit_on = 1'b0, lit_busy, lit_wr;
    logic [W-1:0] lit_data;
    logic [1:0]   lit_gid;
    logic [N-1:0] lit_ready;
    string        lit_tag = "";

    // ---------------- checker-side state ----------------
    int           vectors = 0, miscompares = 0, dut_words = 0;
    logic [N-1:0] hs_vec = '0;
    int           owner = -1, last_served = N - 1, shown_gid = 0, words = 0, idle = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic         exp_wr;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_data;
        int           c;
        exp_wr    = 1'b0;
        exp_ready = '0;
        exp_data  = '0;
        if (owner >= 0 && !reset && !buf_full) begin
            exp_ready[owner] = 1'b1;
            if (req_valid[owner]) begin
                exp_wr   = 1'b1;
                exp_data = req_data[owner*W +: W];
            end
        end
        if (chk_en) begin
            check("buf_wr", 64'(buf_wr), 64'(exp_wr));
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(owner >= 0));
            check("grant_id", 64'(grant_id), 64'(shown_gid));
            if (exp_wr) check("buf_data", 64'(buf_data), 64'(exp_data));
            if (buf_wr === 1'b1) dut_words++;
            $display("cyc t=%0t rst=%0b v=%b full=%0b wr=%0b data=%08h gid=%0d busy=%0b",
                     $time, reset, req_valid, buf_full, buf_wr, buf_data, grant_id, busy);
        end
        if (lit_on) begin
            check({lit_tag, "_busy"}, 64'(busy), 64'(lit_busy));
            check({lit_tag, "_wr"}, 64'(buf_wr), 64'(lit_wr));
            check({lit_tag, "_gid"}, 64'(grant_id), 64'(lit_gid));
            check({lit_tag, "_ready"}, 64'(req_ready), 64'(lit_ready));
            if (lit_wr) check({lit_tag, "_data"}, 64'(buf_data), 64'(lit_data));
        end
        hs_vec = exp_ready & req_valid;

        // Advance the model across the coming edge.
        if (reset) begin
            owner = -1; last_served = N - 1; shown_gid = 0; words = 0; idle = 0;
        end else if (owner < 0) begin
            if (PRIO && req_valid[0]) begin
                owner = 0;
            end else begin
                for (int d = 1; d <= N; d++) begin
                    c = (last_served + d) % N;
                    if (owner < 0 && req_valid[c]) begin
                        owner = c;
                        last_served = c;
                    end
                end
            end
            if (owner >= 0) begin
                shown_gid = owner; words = 0; idle = 0;
            end
        end else if (exp_wr) begin
            words++;
            idle = 0;
            if (req_last[owner] || words == MAXB) owner = -1;
        end else begin
            idle++;
            if (!req_valid[owner] && idle >= STALL) owner = -1;
        end

        if (done) begin
            check("word_count", 64'(dut_words), 64'(words_pushed));
            check("drain_bound", 64'(drain_to), 64'(0));
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic push_word(input int i, input bit last, input logic [W-1:0] d);
        q[i].push_back({last, d});
        words_pushed++;
    endtask

    task automatic drive_inputs();
        logic [W:0] f;
        for (int i = 0; i < N; i++) begin
            if (hs_vec[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (rand_mode) begin
            buf_full = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (pause[i] > 0) pause[i]--;
                else if ($urandom_range(0, 63) == 0) pause[i] = $urandom_range(5, 14);
                if (q[i].size() == 0 && $urandom_range(0, 5) == 0) begin
                    int len;
                    len = $urandom_range(1, 24);
                    for (int k = 0; k < len; k++) push_word(i, k == len - 1, $urandom);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && pause[i] == 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                f = q[i][0];
                req_valid[i]        = 1'b1;
                req_last[i]         = f[W];
                req_data[i*W +: W]  = f[W-1:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[i*W +: W]  = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        lit_on = 1'b0;
        drive_inputs();
    endtask

    task automatic set_lit(input string tag, input bit b, input bit w, input logic [W-1:0] d,
                           input int g, input logic [N-1:0] r);
        lit_tag = tag; lit_busy = b; lit_wr = w; lit_data = d;
        lit_gid = 2'(g); lit_ready = r; lit_on = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < 800) begin
            tick();
            n++;
        end
        if (n >= 800) drain_to = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; buf_full = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < N; i++) pause[i] = 0;

        tick(); chk_en = 1'b1;
        tick(); reset = 1'b0;
        set_lit("reset", 1'b0, 1'b0, '0, 0, 4'b0000);

        // Requester 2, three-word burst.
        push_word(2, 1'b0, 32'hA1); push_word(2, 1'b0, 32'hA2); push_word(2, 1'b1, 32'hA3);
        tick(); set_lit("r2_arb", 1'b0, 1'b0, '0, 0, 4'b0000);
        tick(); set_lit("r2_w1", 1'b1, 1'b1, 32'hA1, 2, 4'b0100);
        tick(); set_lit("r2_w2", 1'b1, 1'b1, 32'hA2, 2, 4'b0100);
        tick(); set_lit("r2_w3", 1'b1, 1'b1, 32'hA3, 2, 4'b0100);
        tick(); set_lit("r2_bubble", 1'b0, 1'b0, '0, 2, 4'b0000);

        // All four requesters, single-word bursts, after a reset.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) push_word(i, 1'b1, 32'hB0 + i);
        tick();
        for (int i = 0; i < N; i++) begin
            tick(); set_lit("rr_grant", 1'b1, 1'b1, 32'hB0 + i, i, 4'(1 << i));
            tick(); set_lit("rr_bubble", 1'b0, 1'b0, '0, i, 4'b0000);
        end
        drain();

        // Burst cap: requester 1 streams 20 words while 0 and 2 also wait.
        for (int k = 0; k < 20; k++) push_word(1, k == 19, 32'h1100 + k);
        push_word(0, 1'b1, 32'h0C0); push_word(2, 1'b1, 32'h2C0);
        drain();

        // buf_full held ten cycles in the middle of a burst.
        for (int k = 0; k < 6; k++) push_word(3, k == 5, 32'hC0 + k);
        tick();
        tick(); set_lit("full_w0", 1'b1, 1'b1, 32'hC0, 3, 4'b1000);
        tick(); set_lit("full_w1", 1'b1, 1'b1, 32'hC1, 3, 4'b1000);
        for (int k = 0; k < 10; k++) begin
            tick(); buf_full = 1'b1; set_lit("full_hold", 1'b1, 1'b0, '0, 3, 4'b0000);
        end
        tick(); buf_full = 1'b0; set_lit("full_resume", 1'b1, 1'b1, 32'hC2, 3, 4'b1000);
        drain();

        // Watchdog: requester 0 goes quiet after two words.
        push_word(0, 1'b0, 32'hD0); push_word(0, 1'b0, 32'hD1);
        tick();
        tick(); set_lit("wd_w0", 1'b1, 1'b1, 32'hD0, 0, 4'b0001);
        tick(); set_lit("wd_w1", 1'b1, 1'b1, 32'hD1, 0, 4'b0001);
        for (int k = 0; k < STALL; k++) begin
            tick(); set_lit("wd_hold", 1'b1, 1'b0, '0, 0, 4'b0001);
            if (k == 2) push_word(1, 1'b1, 32'hE0);
        end
        tick(); set_lit("wd_bubble", 1'b0, 1'b0, '0, 0, 4'b0000);
        tick(); set_lit("wd_next", 1'b1, 1'b1, 32'hE0, 1, 4'b0010);
        drain();

        // Reset in the middle of a burst.
        for (int k = 0; k < 5; k++) push_word(2, k == 4, 32'hF0 + k);
        tick();
        tick(); set_lit("rst_w0", 1'b1, 1'b1, 32'hF0, 2, 4'b0100);
        tick(); set_lit("rst_w1", 1'b1, 1'b1, 32'hF1, 2, 4'b0100);
        tick(); reset = 1'b1; set_lit("rst_cycle", 1'b1, 1'b0, '0, 2, 4'b0000);
        push_word(0, 1'b1, 32'h60);
        tick(); reset = 1'b0; set_lit("rst_after", 1'b0, 1'b0, '0, 0, 4'b0000);
        tick(); set_lit("rst_first", 1'b1, 1'b1, 32'h60, 0, 4'b0001);
        drain();

        // Requesters 0 and 3 contend with the pointer sitting on 2.
        reset = 1'b1; tick(); reset = 1'b0;
        push_word(2, 1'b1, 32'h70);
        tick();
        push_word(0, 1'b1, 32'h71); push_word(3, 1'b1, 32'h73);
        tick(); set_lit("prio_r2", 1'b1, 1'b1, 32'h70, 2, 4'b0100);
        tick(); set_lit("prio_bubble", 1'b0, 1'b0, '0, 2, 4'b0000);
        tick();
        if (PRIO) set_lit("prio_pick", 1'b1, 1'b1, 32'h71, 0, 4'b0001);
        else      set_lit("prio_pick", 1'b1, 1'b1, 32'h73, 3, 4'b1000);
        drain();

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        reset = 1'b0; buf_full = 1'b0;
        for (int i = 0; i < N; i++) pause[i] = 0;
        drain();

        done = 1'b1;
        repeat (4) @(posedge clock);
        $display("FAIL summary: checker did not finish");
        $fatal(1);
    end

endmodule
